// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg                                                           |
// | Shared state encodings and frame constants for the UART TX/RX.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_START   = 3'd1,
        TX_DATA    = 3'd2,
        TX_STOP    = 3'd3,
        TX_CLEANUP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_bit_timer                                                     |
// | Per-bit cycle counter with mid-bit and end-of-bit strobes.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_clear,
    output logic o_mid,
    output logic o_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign o_mid = (cnt_q == CNT_W'((CLKS_PER_BIT - 1) / 2));

    // Counter restarts at each bit boundary so it never runs past CLKS_PER_BIT-1.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clear || o_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rxtx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rxtx                                                          |
// | 8N1 UART transmitter and receiver; UART_RX_SYNC_EN adds a 2-flop   |
// | input synchronizer on i_RX_Serial.                                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_rxtx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------ TX
    tx_state_t  tx_state_q,  tx_state_d;
    logic [7:0] tx_byte_q,   tx_byte_d;
    logic [2:0] tx_idx_q,    tx_idx_d;
    logic       tx_serial_q, tx_serial_d;
    logic       tx_active_q, tx_active_d;
    logic       tx_done_q,   tx_done_d;
    logic       tx_clear;
    logic       tx_end;
    logic       tx_mid_unused;

    assign tx_clear = (tx_state_q == TX_IDLE) || (tx_state_q == TX_CLEANUP);

    // The transmitter only needs bit boundaries, not the mid-bit strobe.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .i_clear (tx_clear),
        .o_mid   (tx_mid_unused),
        .o_end   (tx_end)
    );

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_byte_d   = tx_byte_q;
        tx_idx_d    = tx_idx_q;
        tx_serial_d = tx_serial_q;
        tx_active_d = tx_active_q;
        tx_done_d   = tx_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_serial_d = 1'b1;
                tx_active_d = 1'b0;
                tx_done_d   = 1'b0;
                tx_idx_d    = 3'd0;
                if (i_TX_DV) begin
                    tx_byte_d   = i_TX_Byte;
                    tx_serial_d = 1'b0;
                    tx_active_d = 1'b1;
                    tx_state_d  = TX_START;
                end
            end
            TX_START: begin
                if (tx_end) begin
                    tx_serial_d = tx_byte_q[0];
                    tx_state_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_end) begin
                    if (tx_idx_q == LAST_IDX) begin
                        tx_idx_d    = 3'd0;
                        tx_serial_d = 1'b1;
                        tx_state_d  = TX_STOP;
                    end else begin
                        tx_idx_d    = tx_idx_q + 3'd1;
                        tx_serial_d = tx_byte_q[tx_idx_q + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    tx_done_d   = 1'b1;
                    tx_active_d = 1'b0;
                    tx_serial_d = 1'b1;
                    tx_state_d  = TX_CLEANUP;
                end
            end
            TX_CLEANUP: begin
                tx_done_d  = 1'b0;
                tx_state_d = TX_IDLE;
            end
            default: begin
                tx_serial_d = 1'b1;
                tx_active_d = 1'b0;
                tx_done_d   = 1'b0;
                tx_state_d  = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_state_q  <= TX_IDLE;
            tx_byte_q   <= 8'h00;
            tx_idx_q    <= 3'd0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_byte_q   <= tx_byte_d;
            tx_idx_q    <= tx_idx_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign o_TX_Serial = tx_serial_q;
    assign o_TX_Active = tx_active_q;
    assign o_TX_Done   = tx_done_q;

    // ------------------------------------------------------------ RX input
    logic rx_in;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q;
    logic [1:0] rx_sync_d;

    always_comb begin
        rx_sync_d = {rx_sync_q[0], i_RX_Serial};
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= rx_sync_d;
        end
    end

    assign rx_in = rx_sync_q[1];
`else
    assign rx_in = i_RX_Serial;
`endif

    // ------------------------------------------------------------ RX
    rx_state_t  rx_state_q, rx_state_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q,  rx_byte_d;
    logic [2:0] rx_idx_q,   rx_idx_d;
    logic       rx_dv_q,    rx_dv_d;
    logic       rx_clear;
    logic       rx_mid;
    logic       rx_end;

    // Restarting the timer at the start-bit midpoint makes every later
    // end-of-bit strobe land on a bit centre.
    assign rx_clear = (rx_state_q == RX_IDLE) || (rx_state_q == RX_CLEANUP) ||
                      ((rx_state_q == RX_START) && rx_mid);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .i_clear (rx_clear),
        .o_mid   (rx_mid),
        .o_end   (rx_end)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_idx_d   = rx_idx_q;
        rx_dv_d    = rx_dv_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_dv_d  = 1'b0;
                rx_idx_d = 3'd0;
                if (!rx_in) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_mid) begin
                    rx_state_d = rx_in ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_end) begin
                    rx_shift_d[rx_idx_q] = rx_in;
                    if (rx_idx_q == LAST_IDX) begin
                        rx_idx_d   = 3'd0;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_end) begin
                    if (rx_in) begin
                        rx_byte_d = rx_shift_q;
                        rx_dv_d   = 1'b1;
                    end
                    rx_state_d = RX_CLEANUP;
                end
            end
            RX_CLEANUP: begin
                rx_dv_d    = 1'b0;
                rx_state_d = RX_IDLE;
            end
            default: begin
                rx_dv_d    = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_idx_q   <= 3'd0;
            rx_dv_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_idx_q   <= rx_idx_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    assign o_RX_DV   = rx_dv_q;
    assign o_RX_Byte = rx_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rxtx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rxtx                                                       |
// | Scoreboard bench: loopback and directly driven RX frames.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_rxtx;

    localparam int N = 868;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic       r_tx_dv = 1'b0;
    logic [7:0] r_tx_byte = 8'h00;
    logic       r_rx = 1'b1;
    logic       r_loop = 1'b0;

    logic       w_tx_active;
    logic       w_tx_serial;
    logic       w_tx_done;
    logic       w_rx_dv;
    logic [7:0] w_rx_byte;
    logic       w_rx_line;

    assign w_rx_line = r_loop ? (w_tx_active ? w_tx_serial : 1'b1) : r_rx;

    always #5 r_clk = ~r_clk;

    uart_rxtx #(.CLKS_PER_BIT(N)) dut (
        .i_Clock     (r_clk),
        .i_Rst_L     (r_rst_n),
        .i_TX_DV     (r_tx_dv),
        .i_TX_Byte   (r_tx_byte),
        .o_TX_Active (w_tx_active),
        .o_TX_Serial (w_tx_serial),
        .o_TX_Done   (w_tx_done),
        .i_RX_Serial (w_rx_line),
        .o_RX_DV     (w_rx_dv),
        .o_RX_Byte   (w_rx_byte)
    );

    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         rx_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Received bytes are popped from the scoreboard; 9'h100 marks "nothing expected".
    always @(negedge r_clk) begin
        if (w_tx_done) done_cnt++;
        if (w_rx_dv) begin
            logic [8:0] exp;
            rx_cnt++;
            exp = (exp_q.size() == 0) ? 9'h100 : {1'b0, exp_q.pop_front()};
            check("rx_byte", {23'd0, 1'b0, w_rx_byte}, {23'd0, exp});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit poke);
        int cyc;
        exp_q.push_back(b);
        @(posedge r_clk);
        #1;
        r_tx_dv   = 1'b1;
        r_tx_byte = b;
        cyc = 0;
        while (cyc < 12 * N) begin
            @(posedge r_clk);
            #1;
            cyc++;
            r_tx_dv = 1'b0;
            if (cyc == 1) begin
                check("tx_start_serial", {31'd0, w_tx_serial}, 32'd0);
                check("tx_start_active", {31'd0, w_tx_active}, 32'd1);
            end
            if (poke && cyc == 3 * N) begin
                r_tx_dv   = 1'b1;
                r_tx_byte = 8'h11;
            end
            if (w_tx_done) break;
        end
        check("tx_done_latency", cyc, 10 * N + 1);
        check("tx_cleanup_serial", {31'd0, w_tx_serial}, 32'd1);
        check("tx_cleanup_active", {31'd0, w_tx_active}, 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop_hi);
        if (stop_hi) exp_q.push_back(b);
        @(posedge r_clk);
        #1;
        r_rx = 1'b0;
        wait_cycles(N);
        for (int i = 0; i < 8; i++) begin
            r_rx = b[i];
            wait_cycles(N);
        end
        r_rx = stop_hi;
        wait_cycles(N);
        r_rx = 1'b1;
        wait_cycles(2 * N);
    endtask

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         d0;
        int         r0;
        logic [7:0] pat [3];

        // Reset state
        wait_cycles(3);
        check("rst_tx_serial", {31'd0, w_tx_serial}, 32'd1);
        check("rst_tx_active", {31'd0, w_tx_active}, 32'd0);
        check("rst_tx_done",   {31'd0, w_tx_done},   32'd0);
        check("rst_rx_dv",     {31'd0, w_rx_dv},     32'd0);
        check("rst_rx_byte",   {24'd0, w_rx_byte},   32'h00);
        r_rst_n = 1'b1;
        wait_cycles(4);

        // Loopback 3A with an ignored 11 request mid-frame
        r_loop = 1'b1;
        d0 = done_cnt;
        r0 = rx_cnt;
        tx_frame(8'h3A, 1'b1);
        wait_cycles(2 * N);
        check("tx_done_count_3a", done_cnt - d0, 1);
        check("tx_idle_after_poke", {31'd0, w_tx_active}, 32'd0);
        check("rx_count_3a", rx_cnt - r0, 1);

        // Back-to-back loopback
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h55;
        r0 = rx_cnt;
        for (int i = 0; i < 3; i++) tx_frame(pat[i], 1'b0);
        wait_cycles(N);
        check("rx_count_b2b", rx_cnt - r0, 3);
        check("sb_empty_b2b", exp_q.size(), 0);

        // Short low glitch on RX, then a real frame
        r_loop = 1'b0;
        r_rx = 1'b1;
        r0 = rx_cnt;
        wait_cycles(4);
        r_rx = 1'b0;
        wait_cycles(N / 4);
        r_rx = 1'b1;
        wait_cycles(2 * N);
        check("rx_glitch_no_dv", rx_cnt - r0, 0);
        rx_frame(8'hA5, 1'b1);
        check("rx_count_a5", rx_cnt - r0, 1);
        check("rx_byte_a5", {24'd0, w_rx_byte}, 32'hA5);

        // Framing error: stop bit low
        r0 = rx_cnt;
        rx_frame(8'h3C, 1'b0);
        check("rx_badstop_no_dv", rx_cnt - r0, 0);
        check("rx_badstop_hold", {24'd0, w_rx_byte}, 32'hA5);

        // Reset in the middle of a TX data bit
        d0 = done_cnt;
        @(posedge r_clk);
        #1;
        r_tx_dv   = 1'b1;
        r_tx_byte = 8'h5A;
        wait_cycles(1);
        r_tx_dv = 1'b0;
        wait_cycles(3 * N + N / 2);
        check("pre_rst_active", {31'd0, w_tx_active}, 32'd1);
        #2;
        r_rst_n = 1'b0;
        #1;
        check("midrst_tx_serial", {31'd0, w_tx_serial}, 32'd1);
        check("midrst_tx_active", {31'd0, w_tx_active}, 32'd0);
        check("midrst_rx_byte", {24'd0, w_rx_byte}, 32'h00);
        wait_cycles(2);
        #2;
        r_rst_n = 1'b1;
        wait_cycles(2 * N);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_still_idle", {31'd0, w_tx_active}, 32'd0);
        check("sb_empty_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
